mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADR_WIDTH, default 16, address width of requester and main-memory buses.
REQ-002 Parameter DATA_WIDTH, default 8, data width of all data buses.
REQ-003 Parameter BURST_LEN, default 4, beats per transfer; legal range 1..16.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, WAIT-state cycle limit, used only with ARB_TIMEOUT_EN.
REQ-005 CLK  input  1  clock; all state changes on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 req0 / req1  input  1  transfer request from cache port 0 / 1.
REQ-008 wr0 / wr1  input  1  1 = write burst, 0 = read burst; valid while reqN is high.
REQ-009 adr0 / adr1  input  ADR_WIDTH  burst base address.
REQ-010 wdata0 / wdata1  input  DATA_WIDTH  write data for the current beat.
REQ-011 gnt0 / gnt1  output  1  high for the whole of a transfer owned by port N.
REQ-012 valid0 / valid1  output  1  one-cycle pulse per completed beat.
REQ-013 rdata  output  DATA_WIDTH  read data, valid in the cycle validN pulses.
REQ-014 done0 / done1  output  1  one-cycle pulse at the end of the burst.
REQ-015 err0 / err1  output  1  one-cycle pulse with doneN when a burst is aborted.
REQ-016 adrMM  output  ADR_WIDTH  main-memory address.
REQ-017 dataMM_out  output  DATA_WIDTH  main-memory write data; dataMM_in  input  DATA_WIDTH  main-memory read data.
REQ-018 readMem / writeMem  output  1  memory strobes; readyMem  input  1  memory beat-complete.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-020 IDLE with any reqN high: grant one port, latch wr, adr and port id, set beat=0, go to ISSUE; with no request, stay in IDLE.
REQ-021 Both requests high in IDLE: grant the port that was not granted last (round-robin); a single requester is granted regardless of history.
REQ-022 ISSUE: drive adrMM = base+beat (mod 2^ADR_WIDTH, wrap-around allowed); raise writeMem with dataMM_out = wdataN if wr, else raise readMem; go to WAIT.
REQ-023 WAIT: hold the strobe and adrMM until readyMem = 1; readyMem seen in ISSUE or IDLE is ignored.
REQ-024 On readyMem in WAIT: drop the strobe in the next cycle; capture dataMM_in into rdata on reads; pulse validN; increment beat.
REQ-025 After that beat: if it was beat BURST_LEN-1, go to DONE; otherwise go to ISSUE, giving at least one strobe-low cycle between beats.
REQ-026 Requesters advance wdataN on validN; the arbiter samples wdataN only in ISSUE.
REQ-027 DONE: pulse doneN, record port N as last granted, drop gntN, return to IDLE; a new grant is possible in the cycle after DONE.
REQ-028 Dropping reqN mid-burst has no effect; the burst completes. readMem and writeMem are never high together.
REQ-029 At most one gnt is high at any time; gnt is high from ISSUE of beat 0 through DONE.

Reset
REQ-030 While RST = 0: state = IDLE, beat = 0, last-granted = port 1 (so port 0 wins the first tie), and all outputs = 0.
REQ-031 Reset mid-burst: abort immediately with strobes low; no doneN or errN is issued.

Configuration
REQ-032 With ARB_TIMEOUT_EN defined: a counter clears on entry to WAIT; if it reaches TIMEOUT_CYCLES without readyMem, drop the strobe, go to DONE, and pulse errN together with doneN.
REQ-033 Without ARB_TIMEOUT_EN: WAIT persists until readyMem, and err0/err1 are tied to 0.

Verification
REQ-034 Port0 read at 0x0100, BURST_LEN=4, memory ready 2 cycles after each strobe -> readMem addresses 0x0100..0x0103, four valid0 pulses with memory data, one done0.
REQ-035 req0 and req1 high together from reset -> port0 granted first, then port1; a repeat of both -> port1 is NOT granted twice in a row.
REQ-036 Port1 write at 0xFFFE with data 0xA1..0xA4 -> writeMem addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 with matching dataMM_out.
REQ-037 With ARB_TIMEOUT_EN, readyMem held low -> strobe drops after 255 WAIT cycles, done0 and err0 pulse, return to IDLE.
REQ-038 RST asserted in WAIT of beat 2 -> strobes, gnt and all outputs go to 0 asynchronously; after release, a new req0 is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter giving two cache ports burst access to one main-memory bus.
// Define ARB_TIMEOUT_EN to abort a beat that stays in WAIT for TIMEOUT_CYCLES.
module mem_bus_arbiter #(
   parameter int ADR_WIDTH      = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int BURST_LEN      = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  wr0,
   input  logic                  wr1,
   input  logic [ADR_WIDTH-1:0]  adr0,
   input  logic [ADR_WIDTH-1:0]  adr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  valid0,
   output logic                  valid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done0,
   output logic                  done1,
   output logic                  err0,
   output logic                  err1,
   output logic [ADR_WIDTH-1:0]  adrMM,
   output logic [DATA_WIDTH-1:0] dataMM_out,
   input  logic [DATA_WIDTH-1:0] dataMM_in,
   output logic                  readMem,
   output logic                  writeMem,
   input  logic                  readyMem
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t                state_q, state_d;
   logic                  port_q, port_d, last_q, last_d, wr_q, wr_d;
   logic                  rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d, valid_q, valid_d;
   logic [ADR_WIDTH-1:0]  base_q, base_d, adr_q, adr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d, wdat_q, wdat_d;
   logic [4:0]            beat_q, beat_d;
   logic                  pick;
`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  err_q, err_d;
`endif
   // on a tie the port not granted last wins; a lone requester always wins
   assign pick = (req0 && req1) ? ~last_q : req1;
   always_comb begin
      state_d  = state_q;
      port_d   = port_q;
      last_d   = last_q;
      wr_d     = wr_q;
      base_d   = base_q;
      adr_d    = adr_q;
      wdat_d   = wdat_q;
      rdata_d  = rdata_q;
      beat_d   = beat_q;
      rd_stb_d = rd_stb_q;
      wr_stb_d = wr_stb_q;
      valid_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: if (req0 || req1) begin
            state_d = ISSUE;
            port_d  = pick;
            wr_d    = pick ? wr1 : wr0;
            base_d  = pick ? adr1 : adr0;
            beat_d  = '0;
`ifdef ARB_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         ISSUE: begin
            state_d  = WAIT;
            adr_d    = base_q + ADR_WIDTH'(beat_q);
            wdat_d   = wr_q ? (port_q ? wdata1 : wdata0) : wdat_q;
            rd_stb_d = ~wr_q;
            wr_stb_d = wr_q;
`ifdef ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
         end
         WAIT: if (readyMem) begin
            state_d  = (beat_q == 5'(BURST_LEN - 1)) ? DONE : ISSUE;
            rd_stb_d = 1'b0;
            wr_stb_d = 1'b0;
            valid_d  = 1'b1;
            rdata_d  = wr_q ? rdata_q : dataMM_in;
            beat_d   = beat_q + 5'd1;
         end
`ifdef ARB_TIMEOUT_EN
         else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = DONE;
            rd_stb_d = 1'b0;
            wr_stb_d = 1'b0;
            err_d    = 1'b1;
         end else cnt_d = cnt_q + CW'(1);
`endif
         DONE: begin
            state_d = IDLE;
            last_d  = port_q;
         end
      endcase
   end
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state_q  <= IDLE;
         port_q   <= 1'b0;
         last_q   <= 1'b1;
         wr_q     <= 1'b0;
         base_q   <= '0;
         adr_q    <= '0;
         wdat_q   <= '0;
         rdata_q  <= '0;
         beat_q   <= '0;
         rd_stb_q <= 1'b0;
         wr_stb_q <= 1'b0;
         valid_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         port_q   <= port_d;
         last_q   <= last_d;
         wr_q     <= wr_d;
         base_q   <= base_d;
         adr_q    <= adr_d;
         wdat_q   <= wdat_d;
         rdata_q  <= rdata_d;
         beat_q   <= beat_d;
         rd_stb_q <= rd_stb_d;
         wr_stb_q <= wr_stb_d;
         valid_q  <= valid_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   assign gnt0       = (state_q != IDLE) && !port_q;
   assign gnt1       = (state_q != IDLE) && port_q;
   assign done0      = (state_q == DONE) && !port_q;
   assign done1      = (state_q == DONE) && port_q;
   assign valid0     = valid_q && !port_q;
   assign valid1     = valid_q && port_q;
   assign rdata      = rdata_q;
   assign adrMM      = adr_q;
   assign dataMM_out = wdat_q;
   assign readMem    = rd_stb_q;
   assign writeMem   = wr_stb_q;
`ifdef ARB_TIMEOUT_EN
   assign err0       = done0 && err_q;
   assign err1       = done1 && err_q;
`else
   assign err0       = 1'b0;
   assign err1       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized two-port burst traffic against a transaction-level model.
// Define ARB_TIMEOUT_EN to also exercise the WAIT timeout abort.
module tb_mem_bus_arbiter;
   localparam int BL = 4;
   logic CLK, RST, req0, req1, wr0, wr1, gnt0, gnt1, valid0, valid1;
   logic done0, done1, err0, err1, readMem, writeMem, readyMem;
   logic [15:0] adr0, adr1, adrMM;
   logic [7:0]  wdata0, wdata1, rdata, dataMM_out, dataMM_in;
   typedef struct {logic [15:0] a; logic w; logic [7:0] d;} ev_t;
   typedef struct {logic p; logic [7:0] d;} vl_t;
   typedef struct {logic p; logic e;} dn_t;
   ev_t evq[$];
   vl_t vq[$];
   dn_t dq[$];
   int total = 0, bad = 0, lat = 1, mcnt = 0, widx0 = 0, widx1 = 0;
   logic noise = 0, stall = 0, last = 1;
   logic        pw[2];
   logic [15:0] pa[2];
   logic [7:0]  pb[2];

   mem_bus_arbiter dut (
      .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1), .rdata(rdata),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1), .adrMM(adrMM),
      .dataMM_out(dataMM_out), .dataMM_in(dataMM_in), .readMem(readMem),
      .writeMem(writeMem), .readyMem(readyMem));

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [7:0] memf(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // memory: answers each strobe after lat extra cycles, may toggle readyMem while idle
   initial forever begin
      @(negedge CLK);
      if (!RST) begin
         readyMem = 0;
         mcnt = 0;
      end else if (readMem || writeMem) begin
         mcnt++;
         if (!stall && mcnt > lat) begin
            readyMem = 1;
            dataMM_in = memf(adrMM);
            evq.push_back('{adrMM, writeMem, dataMM_out});
            mcnt = 0;
         end else readyMem = 0;
      end else begin
         mcnt = 0;
         readyMem = noise && ($urandom_range(0, 3) == 0);
         dataMM_in = 8'($urandom);
      end
   end

   // requester side: record pulses, advance write data on valid, check invariants
   initial forever begin
      @(negedge CLK);
      chk("one_gnt", gnt0 && gnt1, 0);
      chk("one_strobe", readMem && writeMem, 0);
      if (valid0 || valid1) vq.push_back('{valid1, rdata});
      if (done0 || done1) dq.push_back('{done1, err0 | err1});
      if (valid0) begin widx0++; wdata0 = 8'(pb[0] + widx0); end
      if (valid1) begin widx1++; wdata1 = 8'(pb[1] + widx1); end
   end

   task automatic rnd(input int k);
      pw[k] = 1'($urandom_range(0, 1));
      pa[k] = 16'($urandom);
      pb[k] = 8'($urandom);
   endtask

   task automatic run(input logic [1:0] mask);
      logic [1:0] pend;
      logic p;
      int n;
      dn_t d;
      pend = mask;
      evq.delete(); vq.delete(); dq.delete();
      wr0 = pw[0]; adr0 = pa[0]; wdata0 = pb[0]; widx0 = 0;
      wr1 = pw[1]; adr1 = pa[1]; wdata1 = pb[1]; widx1 = 0;
      req0 = mask[0]; req1 = mask[1];
      while (pend != 0) begin
         p = (pend == 2'b11) ? ~last : pend[1];
         n = 0;
         while (dq.size() == 0 && n < 400) begin
            @(posedge CLK); #1;
            n++;
            if (gnt0) req0 = 0;
            if (gnt1) req1 = 0;
         end
         chk("done_seen", dq.size() > 0, 1);
         if (dq.size() == 0) begin
            pend = 0; req0 = 0; req1 = 0;
         end else begin
            d = dq.pop_front();
            chk("done_port", d.p, p);
            chk("done_err", d.e, 0);
            chk("beats", evq.size(), BL);
            chk("valids", vq.size(), BL);
            foreach (evq[i]) begin
               chk("adr", evq[i].a, 16'(pa[p] + i));
               chk("dir", evq[i].w, pw[p]);
               if (pw[p]) chk("wdat", evq[i].d, 8'(pb[p] + i));
            end
            foreach (vq[i]) begin
               chk("vport", vq[i].p, p);
               if (!pw[p]) chk("rdat", vq[i].d, memf(16'(pa[p] + i)));
            end
            last = p;
            pend[p] = 0;
            evq.delete(); vq.delete();
         end
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      int n;
      dn_t d;
      RST = 0; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; adr0 = 0; adr1 = 0;
      wdata0 = 0; wdata1 = 0; dataMM_in = 0; readyMem = 0;
      #1;
      chk("rst_out", {gnt0, gnt1, valid0, valid1, done0, done1, err0, err1, readMem, writeMem, adrMM, dataMM_out, rdata}, 0);
      repeat (3) @(posedge CLK);
      #3 RST = 1;
      @(posedge CLK); #1;
      chk("idle_out", {gnt0, gnt1, readMem, writeMem}, 0);
      // simultaneous requests from reset, twice
      rnd(0); rnd(1);
      run(2'b11);
      rnd(0); rnd(1);
      run(2'b11);
      // port0 read burst at 0x0100
      lat = 2;
      pw[0] = 0; pa[0] = 16'h0100; pb[0] = 0;
      run(2'b01);
      // port1 write burst wrapping past 0xFFFF
      lat = 1;
      pw[1] = 1; pa[1] = 16'hFFFE; pb[1] = 8'hA1;
      run(2'b10);
      // random traffic with spurious readyMem outside WAIT
      noise = 1;
      for (int k = 0; k < 20; k++) begin
         lat = $urandom_range(0, 3);
         rnd(0); rnd(1);
         run(2'($urandom_range(1, 3)));
      end
      noise = 0;
      // reset while beat 2 waits for memory
      lat = 3;
      pw[0] = 0; pa[0] = 16'h1230; pb[0] = 0;
      adr0 = pa[0]; wr0 = 0; req0 = 1;
      evq.delete(); vq.delete(); dq.delete();
      n = 0;
      while (!(evq.size() == 2 && readMem) && n < 200) begin
         @(posedge CLK); #1;
         n++;
         if (gnt0) req0 = 0;
      end
      chk("reach_beat2", n < 200, 1);
      #2 RST = 0;
      #1;
      chk("async_rst", {gnt0, gnt1, valid0, valid1, done0, done1, err0, err1, readMem, writeMem, adrMM, dataMM_out, rdata}, 0);
      repeat (3) @(posedge CLK);
      #1;
      chk("no_done_rst", dq.size(), 0);
      RST = 1;
      last = 1;
      lat = 1;
      rnd(0);
      run(2'b01);
`ifdef ARB_TIMEOUT_EN
      stall = 1;
      pw[0] = 0; pa[0] = 16'h0200;
      adr0 = pa[0]; wr0 = 0; req0 = 1;
      evq.delete(); vq.delete(); dq.delete();
      n = 0;
      while (!readMem && n < 50) begin
         @(posedge CLK); #1;
         n++;
      end
      req0 = 0;
      n = 0;
      while (readMem && n < 400) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("to_cycles", n, 255);
      chk("to_done", dq.size(), 1);
      if (dq.size() > 0) begin
         d = dq.pop_front();
         chk("to_port", d.p, 0);
         chk("to_err", d.e, 1);
      end
      @(posedge CLK); #1;
      chk("to_idle", {gnt0, gnt1, readMem, writeMem}, 0);
      stall = 0;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
